// File: rtl/bit_pair_scan_ctrl_if.sv
// Word handshake between a producer and the bit-pair scanner.
// Producer drives start/abort/data_in; scanner returns status and result.
interface bit_pair_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CW-1:0]    pair_count;
  logic             any_pair;

  modport master (
    output start, abort, data_in,
    input  busy, done, pair_count, any_pair
  );

  modport slave (
    input  start, abort, data_in,
    output busy, done, pair_count, any_pair
  );
endinterface

// File: rtl/bit_pair_scan_ctrl.sv
// Serialises a word LSB first and counts adjacent equal-bit pairs.
// Result is registered and only moves on completion, abort or reset.
module bit_pair_scan_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic reset,
  bit_pair_scan_ctrl_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic             prev_bit;
  logic             prev_valid;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [CW-1:0]    pair_q;
  logic             any_q;
  logic             hit;
  logic             last;
  logic             accept;
  logic             step;
  logic             finish;
  logic             kill;

  assign hit   = prev_valid && (shreg[0] == prev_bit);
  assign cnt_n = cnt + CW'(hit);
  assign last  = (idx == IW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    kill    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        // abort wins over the final-bit transition
        if (bus.abort) begin
          kill    = 1'b1;
          state_n = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            finish  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = SCAN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      idx        <= '0;
      prev_bit   <= 1'b0;
      prev_valid <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      shreg      <= bus.data_in;
      idx        <= '0;
      prev_valid <= 1'b0;
      cnt        <= '0;
    end else if (step) begin
      shreg      <= shreg >> 1;
      idx        <= idx + 1'b1;
      prev_bit   <= shreg[0];
      prev_valid <= 1'b1;
      cnt        <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_q <= '0;
      any_q  <= 1'b0;
    end else if (finish) begin
      pair_q <= cnt_n;
      any_q  <= (cnt_n != '0);
    end else if (kill) begin
      pair_q <= '0;
      any_q  <= 1'b0;
    end
  end

  assign bus.busy       = (state == SCAN);
  assign bus.done       = (state == DONE);
  assign bus.pair_count = pair_q;
  assign bus.any_pair   = any_q;

endmodule
